// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
// State encodings double as the LED code driven on the state output.
package alarm_pkg;

    localparam int unsigned DigitW = 4;
    localparam int unsigned TimeW  = 4 * DigitW;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } alarm_state_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse when a synchronous level goes 0 -> 1.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: matches BCD HH:MM against the alarm setting, rings a beeping
// buzzer on the match edge, with bounded snooze and a stop button.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned CNT_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [TimeW-1:0] clock_time,
    input  logic [TimeW-1:0] alarm_time,
    input  logic             alarm_arm,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    output logic             ringing,
    output logic             buzzer,
    output logic             snoozing,
    output logic [1:0]       snooze_left,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] RingLast   = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SnoozeLast = CNT_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]       MaxSnz     = 2'(MAX_SNOOZE);

    logic tick, snz, stp;
    logic match, match_q, trig;

    alarm_state_e     state_q, state_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             beep_q, beep_d;

    logic       ringing_q, buzzer_q, snoozing_q;
    logic [1:0] snooze_left_q, state_out_q;

    edge_pulse u_tick (
        .clk   (clk),
        .rst   (rst),
        .in    (tick_1hz),
        .pulse (tick)
    );

    edge_pulse u_snooze (
        .clk   (clk),
        .rst   (rst),
        .in    (snooze_btn),
        .pulse (snz)
    );

    edge_pulse u_stop (
        .clk   (clk),
        .rst   (rst),
        .in    (stop_btn),
        .pulse (stp)
    );

    assign match = (clock_time == alarm_time);
    assign trig  = match & ~match_q;

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        beep_d       = beep_q;
        if (!alarm_arm) begin
            state_d      = StIdle;
            sec_cnt_d    = '0;
            snooze_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    if (trig) begin
                        state_d   = StRinging;
                        sec_cnt_d = '0;
                        beep_d    = 1'b1;
                    end
                end
                StRinging: begin
                    // An exhausted snooze press falls through to tick handling.
                    if (stp) begin
                        state_d      = StArmed;
                        snooze_cnt_d = '0;
                    end else if (snz && (snooze_cnt_q < MaxSnz)) begin
                        state_d      = StSnooze;
                        sec_cnt_d    = '0;
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                    end else if (tick) begin
                        if (sec_cnt_q == RingLast) begin
                            state_d      = StArmed;
                            snooze_cnt_d = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + CNT_W'(1);
                            beep_d    = ~beep_q;
                        end
                    end
                end
                StSnooze: begin
                    if (stp) begin
                        state_d      = StArmed;
                        snooze_cnt_d = '0;
                    end else if (tick) begin
                        if (sec_cnt_q == SnoozeLast) begin
                            state_d   = StRinging;
                            sec_cnt_d = '0;
                            beep_d    = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // match_q resets high so the 00:00 == 00:00 reset condition is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sec_cnt_q    <= '0;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b0;
            match_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            beep_q       <= beep_d;
            match_q      <= match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ringing_q     <= 1'b0;
            buzzer_q      <= 1'b0;
            snoozing_q    <= 1'b0;
            snooze_left_q <= MaxSnz;
            state_out_q   <= 2'd0;
        end else begin
            ringing_q     <= (state_q == StRinging);
            buzzer_q      <= (state_q == StRinging) & beep_q;
            snoozing_q    <= (state_q == StSnooze);
            snooze_left_q <= MaxSnz - snooze_cnt_q;
            state_out_q   <= state_q;
        end
    end

    assign ringing     = ringing_q;
    assign buzzer      = buzzer_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = snooze_left_q;
    assign state       = state_out_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
module tb_alarm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_1hz;
    logic [15:0] clock_time;
    logic [15:0] alarm_time;
    logic        alarm_arm;
    logic        snooze_btn;
    logic        stop_btn;
    logic        ringing;
    logic        buzzer;
    logic        snoozing;
    logic [1:0]  snooze_left;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    alarm_ctrl #(
        .RING_SEC   (4),
        .SNOOZE_SEC (3),
        .MAX_SNOOZE (2),
        .CNT_W      (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .clock_time  (clock_time),
        .alarm_time  (alarm_time),
        .alarm_arm   (alarm_arm),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .ringing     (ringing),
        .buzzer      (buzzer),
        .snoozing    (snoozing),
        .snooze_left (snooze_left),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        step(1);
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        step(1);
        snooze_btn = 1'b0;
        step(1);
    endtask

    // Move away from the alarm minute and back to produce a fresh match edge.
    task automatic re_ring();
        clock_time = 16'h0731;
        step(2);
        clock_time = 16'h0730;
        step(2);
    endtask

    initial begin
        int bad;
        rst        = 1'b1;
        tick_1hz   = 1'b0;
        clock_time = 16'h0000;
        alarm_time = 16'h0000;
        alarm_arm  = 1'b1;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        step(2);
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_ringing", {15'd0, ringing}, 16'd0);
        check("rst_snooze_left", {14'd0, snooze_left}, 16'd2);
        rst = 1'b0;
        step(3);
        check("armed_after_rst", {14'd0, state}, 16'd1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (ringing !== 1'b0) bad++;
        end
        check("no_ring_1000clk", bad[15:0], 16'd0);

        // Match edge 0729 -> 0730 rings two clocks later.
        alarm_time = 16'h0730;
        clock_time = 16'h0729;
        step(2);
        clock_time = 16'h0730;
        step(1);
        check("ring_lat_1clk", {15'd0, ringing}, 16'd0);
        step(1);
        check("ring_lat_2clk", {15'd0, ringing}, 16'd1);
        check("buzz_start", {15'd0, buzzer}, 16'd1);
        check("state_ringing", {14'd0, state}, 16'd2);
        do_tick();
        check("buzz_t1", {15'd0, buzzer}, 16'd0);
        do_tick();
        check("buzz_t2", {15'd0, buzzer}, 16'd1);
        do_tick();
        check("buzz_t3", {15'd0, buzzer}, 16'd0);
        check("ring_t3", {15'd0, ringing}, 16'd1);
        do_tick();
        check("autosil_ringing", {15'd0, ringing}, 16'd0);
        check("autosil_state", {14'd0, state}, 16'd1);
        step(5);
        check("no_rering_same_match", {15'd0, ringing}, 16'd0);

        // Snooze twice, third press ignored, then stop.
        re_ring();
        check("ring2", {15'd0, ringing}, 16'd1);
        press_snooze();
        check("snz1_snoozing", {15'd0, snoozing}, 16'd1);
        check("snz1_left", {14'd0, snooze_left}, 16'd1);
        check("snz1_ringing", {15'd0, ringing}, 16'd0);
        clock_time = 16'h0731;
        do_tick();
        clock_time = 16'h0730;
        do_tick();
        check("snz1_mid", {15'd0, snoozing}, 16'd1);
        do_tick();
        check("snz1_rering", {15'd0, ringing}, 16'd1);
        check("snz1_rering_buzz", {15'd0, buzzer}, 16'd1);
        press_snooze();
        check("snz2_left", {14'd0, snooze_left}, 16'd0);
        check("snz2_snoozing", {15'd0, snoozing}, 16'd1);
        repeat (3) do_tick();
        check("snz2_rering", {15'd0, ringing}, 16'd1);
        press_snooze();
        check("snz3_ignored_ring", {15'd0, ringing}, 16'd1);
        check("snz3_ignored_snz", {15'd0, snoozing}, 16'd0);
        check("snz3_left", {14'd0, snooze_left}, 16'd0);
        stop_btn = 1'b1;
        step(1);
        stop_btn = 1'b0;
        step(1);
        check("stop_state", {14'd0, state}, 16'd1);
        check("stop_left", {14'd0, snooze_left}, 16'd2);

        // Snooze and stop in the same cycle: stop wins.
        re_ring();
        press_snooze();
        check("both_pre_left", {14'd0, snooze_left}, 16'd1);
        repeat (3) do_tick();
        check("both_pre_ring", {15'd0, ringing}, 16'd1);
        snooze_btn = 1'b1;
        stop_btn   = 1'b1;
        step(1);
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        step(1);
        check("both_state", {14'd0, state}, 16'd1);
        check("both_snoozing", {15'd0, snoozing}, 16'd0);
        check("both_left", {14'd0, snooze_left}, 16'd2);

        // Disarm while ringing, re-arm on the still-matching minute.
        re_ring();
        check("disarm_pre_buzz", {15'd0, buzzer}, 16'd1);
        alarm_arm = 1'b0;
        step(2);
        check("disarm_state", {14'd0, state}, 16'd0);
        check("disarm_buzz", {15'd0, buzzer}, 16'd0);
        alarm_arm = 1'b1;
        step(4);
        check("rearm_state", {14'd0, state}, 16'd1);
        check("rearm_no_ring", {15'd0, ringing}, 16'd0);

        // Reset in the middle of a snooze count.
        re_ring();
        press_snooze();
        do_tick();
        check("mid_snz", {15'd0, snoozing}, 16'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_state", {14'd0, state}, 16'd0);
        check("mrst_snoozing", {15'd0, snoozing}, 16'd0);
        check("mrst_ringing", {15'd0, ringing}, 16'd0);
        check("mrst_buzz", {15'd0, buzzer}, 16'd0);
        check("mrst_left", {14'd0, snooze_left}, 16'd2);
        repeat (5) do_tick();
        check("mrst_armed", {14'd0, state}, 16'd1);
        check("mrst_no_ring", {15'd0, ringing}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream of the clock/alarm time block.
- Consumes the BCD HH:MM clock value and the BCD HH:MM alarm setting, detects the minute the two match, and drives a beeping buzzer.
- Supports bounded snooze and a stop button.
- Sequenced by the 1 Hz divided clock, which is sampled as a level and converted to an internal one-cycle strobe.

Parameters:
- RING_SEC, 60, seconds of ringing before auto-silence back to ARMED
- SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing
- MAX_SNOOZE, 3, snooze presses allowed per alarm event
- CNT_W, 9, width of the seconds counter; must hold max(RING_SEC, SNOOZE_SEC)

Ports:
- clk  in  1  system clock (the only clock in the block)
- rst  in  1  reset, synchronous, active-high
- tick_1hz  in  1  1 Hz square wave from the divider; treated as level, synchronous to clk
- clock_time  in  16  current time, BCD {H1,H0,M1,M0}
- alarm_time  in  16  alarm setting, BCD {H1,H0,M1,M0}
- alarm_arm  in  1  level; 1 = alarm enabled
- snooze_btn  in  1  debounced level button
- stop_btn  in  1  debounced level button
- ringing  out  1  1 while in RINGING
- buzzer  out  1  beep drive, toggles each second while ringing
- snoozing  out  1  1 while in SNOOZE
- snooze_left  out  2  snoozes remaining
- state  out  2  encoded FSM state, for LEDs

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. clk is the clock port and rst is the reset port.
- Strobes:
  - tick = tick_1hz & ~tick_q
  - snz = snooze_btn & ~snz_q
  - stp = stop_btn & ~stp_q
  - All previous-value registers reset to 0.
- Match:
  - match = (clock_time == alarm_time), a raw 16-bit compare with no BCD validation.
  - trig = match & ~match_q.
  - match_q resets to 1. Both time sources reset to 00:00, so reset must not cause a spurious ring.
- FSM states: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3. Reset -> IDLE, sec_cnt=0, snooze_cnt=0.
- Transitions, one per cycle; priority is listed top to bottom:
  - any state, alarm_arm=0 -> IDLE. Clear sec_cnt and snooze_cnt. Buzzer is 0 on the next cycle.
  - IDLE, alarm_arm=1 -> ARMED.
  - ARMED, trig -> RINGING. sec_cnt=0, beep_phase=1.
  - RINGING, stp -> ARMED. snooze_cnt=0. If snz and stp occur together, stop wins.
  - RINGING, snz and snooze_cnt<MAX_SNOOZE -> SNOOZE. sec_cnt=0, snooze_cnt+1.
  - RINGING, snz and snooze_cnt==MAX_SNOOZE -> the press is ignored.
  - RINGING, tick and sec_cnt==RING_SEC-1 -> ARMED. snooze_cnt=0.
  - RINGING, other tick -> sec_cnt+1, toggle beep_phase.
  - SNOOZE, stp -> ARMED. snooze_cnt=0.
  - SNOOZE, tick and sec_cnt==SNOOZE_SEC-1 -> RINGING. sec_cnt=0, beep_phase=1.
  - SNOOZE, other tick -> sec_cnt+1.
- Events ignored outside their states:
  - trig is ignored outside ARMED, including during SNOOZE and RINGING.
  - A new match edge after auto-silence re-rings only on a later match.
- Outputs are registered and valid the cycle after the state update.
  - ringing = (state==RINGING).
  - buzzer = ringing & beep_phase.
  - snoozing = (state==SNOOZE).
  - snooze_left = MAX_SNOOZE - snooze_cnt.
  - All outputs are 0 on reset, except snooze_left=MAX_SNOOZE.
- Latency:
  - trig to ringing=1: 1 cycle after the match edge is registered (2 clk after clock_time changes).
  - Button edge to state change: 2 clk.
- Reset mid-RINGING or mid-SNOOZE returns to IDLE immediately at the clock edge. No ring follows even if the times still match (match_q=1).
- A change to alarm_time while ARMED that makes match true produces a trig and rings. This is intended.

Decomposition:
- Shared package alarm_pkg holds:
  - state encodings IDLE/ARMED/RINGING/SNOOZE
  - BCD digit width 4 and time width 16
- One sub-module, edge_pulse (clk, rst, in, pulse), instanced three times for tick, snooze and stop. Reset value of its register is 0.

Test Plan:
All scenarios use RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
- Reset with clock_time=alarm_time=16'h0000, alarm_arm=1 -> state reaches ARMED; ringing stays 0 for 1000 clk.
- Armed, alarm_time=16'h0730, clock_time steps 0729->0730 -> ringing=1 two clk later; buzzer toggles each tick edge; after 4 ticks ringing=0, state=ARMED.
- Ringing, pulse snooze_btn -> snoozing=1, snooze_left=1; after 3 ticks ringing=1. Second snooze -> snooze_left=0. Third snooze is ignored, and ringing stays 1.
- Ringing, snooze_btn and stop_btn rise in the same cycle -> state=ARMED, snoozing=0, snooze_left=2.
- Ringing, drop alarm_arm -> state=IDLE and buzzer=0 the next cycle. Re-arm while clock_time is still 0730 -> no ring.
- SNOOZE mid-count, assert rst for 1 clk -> all outputs at reset values; no ring after release.
